// File: rtl/regex_char_sequencer.sv
//------------------------------------------------------------------------------
// regex_char_sequencer
//   Feeds a byte stream one character at a time to compiled_regex, then runs a
//   final flush pass, and forwards match positions on a valid/ready port.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module regex_char_sequencer #(
  parameter int POS_W        = 32,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_reset,
  output logic [7:0]       m_char,
  output logic             m_last,
  input  logic             m_rdy,
  input  logic             m_match,
  input  logic [POS_W-1:0] m_start,
  input  logic [POS_W-1:0] m_end,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [POS_W-1:0] r_start,
  output logic [POS_W-1:0] r_end,
  output logic             r_flush,
  output logic [31:0]      chars_seen,
  output logic             done,
  output logic             err
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RC_W-1:0] C_RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  state_t           state_q;
  logic [RC_W-1:0]  rc_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             last_pending_q;
  logic             s_ready_q;
  logic             m_reset_q;
  logic [7:0]       m_char_q;
  logic             m_last_q;
  logic             r_valid_q;
  logic [POS_W-1:0] r_start_q;
  logic [POS_W-1:0] r_end_q;
  logic             r_flush_q;
  logic [31:0]      chars_seen_q;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      rc_cnt_q       <= '0;
      to_cnt_q       <= '0;
      last_pending_q <= 1'b0;
      s_ready_q      <= 1'b0;
      m_reset_q      <= 1'b0;
      m_char_q       <= '0;
      m_last_q       <= 1'b0;
      r_valid_q      <= 1'b0;
      r_start_q      <= '0;
      r_end_q        <= '0;
      r_flush_q      <= 1'b0;
      chars_seen_q   <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_ready_q && s_valid) begin
            s_ready_q      <= 1'b0;
            m_char_q       <= s_data;
            last_pending_q <= s_last;
            m_last_q       <= 1'b0;
            chars_seen_q   <= chars_seen_q + 32'd1;
            m_reset_q      <= 1'b1;
            rc_cnt_q       <= '0;
            state_q        <= ST_PULSE;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (rc_cnt_q == C_RC_LAST) begin
            m_reset_q <= 1'b0;
            to_cnt_q  <= '0;
            state_q   <= ST_WAIT;
          end else begin
            rc_cnt_q <= rc_cnt_q + RC_W'(1);
          end
        end
        ST_WAIT: begin
          // m_rdy takes priority over the timeout terminal count
          if (m_rdy) begin
            if (m_match) begin
              r_start_q <= m_start;
              r_end_q   <= m_end;
              r_flush_q <= m_last_q;
              r_valid_q <= 1'b1;
              state_q   <= ST_REPORT;
            end else begin
              state_q <= ST_NEXT;
            end
          end else if (to_cnt_q == C_TO_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_REPORT: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (m_last_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (last_pending_q) begin
            m_last_q  <= 1'b1;
            m_reset_q <= 1'b1;
            rc_cnt_q  <= '0;
            state_q   <= ST_PULSE;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_DONE, ST_ERR: begin
          s_ready_q <= 1'b0;
          m_reset_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign m_reset    = m_reset_q;
  assign m_char     = m_char_q;
  assign m_last     = m_last_q;
  assign r_valid    = r_valid_q;
  assign r_start    = r_start_q;
  assign r_end      = r_end_q;
  assign r_flush    = r_flush_q;
  assign chars_seen = chars_seen_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regex_char_sequencer.sv
//------------------------------------------------------------------------------
// tb_regex_char_sequencer
//   Stub matcher plus pulse/result scoreboards for regex_char_sequencer.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regex_char_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        m_reset;
  logic [7:0]  m_char;
  logic        m_last;
  logic        m_rdy;
  logic        m_match;
  logic [31:0] m_start;
  logic [31:0] m_end;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic [31:0] r_start;
  logic [31:0] r_end;
  logic        r_flush;
  logic [31:0] chars_seen;
  logic        done;
  logic        err;

  regex_char_sequencer #(.POS_W(32), .RESET_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_reset(m_reset), .m_char(m_char), .m_last(m_last),
    .m_rdy(m_rdy), .m_match(m_match), .m_start(m_start), .m_end(m_end),
    .r_valid(r_valid), .r_ready(r_ready), .r_start(r_start), .r_end(r_end),
    .r_flush(r_flush), .chars_seen(chars_seen), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stub matcher: rdy rises stub_delay cycles after m_reset falls, match on one chosen pass
  logic        stub_clr = 1'b1;
  logic        stub_never = 1'b0;
  int          stub_delay = 0;
  int          stub_match_pass = 0;
  logic [31:0] stub_start = '0;
  logic [31:0] stub_end = '0;
  int          pass_idx;
  int          stub_cnt;
  logic        prev_mr;

  always @(posedge clk) begin
    if (stub_clr) begin
      pass_idx <= 0;
      stub_cnt <= 0;
      prev_mr  <= 1'b0;
    end else begin
      prev_mr <= m_reset;
      if (m_reset && !prev_mr) pass_idx <= pass_idx + 1;
      if (m_reset) stub_cnt <= 0;
      else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
    end
  end

  assign m_rdy   = !stub_never && (pass_idx > 0) && !m_reset && (stub_cnt >= stub_delay);
  assign m_match = (pass_idx == stub_match_pass);
  assign m_start = stub_start;
  assign m_end   = stub_end;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
    logic [7:0] width;
  } pulse_t;

  typedef struct packed {
    logic [31:0] st;
    logic [31:0] en;
    logic        fl;
  } res_t;

  pulse_t exp_p[$];
  res_t   exp_r[$];

  int         pw = 0;
  logic [7:0] p_ch;
  logic       p_last;
  pulse_t     pe;
  res_t       re;
  logic       hold_v = 1'b0;
  res_t       hold_d;

  // Matcher-reset pulse scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      pw = 0;
    end else if (m_reset) begin
      if (pw == 0) begin
        p_ch   = m_char;
        p_last = m_last;
      end
      pw++;
    end else if (pw != 0) begin
      if (exp_p.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got char 0x%0h last %0d expected none", p_ch, p_last);
      end else begin
        pe = exp_p.pop_front();
        chk("pulse_char", p_ch, pe.ch);
        chk("pulse_last", p_last, pe.last);
        chk("pulse_width", pw, pe.width);
      end
      pw = 0;
    end
  end

  // Result scoreboard and backpressure stability
  always @(negedge clk) begin
    if (reset && r_valid) begin
      if (hold_v) begin
        chk("hold_start", r_start, hold_d.st);
        chk("hold_end", r_end, hold_d.en);
        chk("hold_flush", r_flush, hold_d.fl);
      end
      hold_v = !r_ready;
      hold_d = '{st: r_start, en: r_end, fl: r_flush};
      if (r_ready) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got start %0d end %0d flush %0d expected none",
                   r_start, r_end, r_flush);
        end else begin
          re = exp_r.pop_front();
          chk("r_start", r_start, re.st);
          chk("r_end", r_end, re.en);
          chk("r_flush", r_flush, re.fl);
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          delay;
    int          mpass;
    logic [31:0] st;
    logic [31:0] en;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    reset    = 1'b0;
    stub_clr = 1'b1;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    r_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_p.delete();
    exp_r.delete();
    reset    = 1'b1;
    stub_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int k;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (k == 200) chk("s_ready_wait", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 300) chk("done_wait", done, 1);
  endtask

  task automatic wait_mreset(input logic lvl);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_reset == lvl) break;
    end
    if (k == 200) chk("m_reset_wait", m_reset, lvl);
  endtask

  task automatic setup_vec(input vec_t v);
    do_reset();
    stub_never      = 1'b0;
    stub_delay      = v.delay;
    stub_match_pass = v.mpass;
    stub_start      = v.st;
    stub_end        = v.en;
    for (int i = 0; i < v.n; i++)
      exp_p.push_back('{ch: v.bytes[8*i +: 8], last: 1'b0, width: 8'd2});
    exp_p.push_back('{ch: v.bytes[8*(v.n-1) +: 8], last: 1'b1, width: 8'd2});
    if (v.mpass >= 1 && v.mpass <= v.n + 1)
      exp_r.push_back('{st: v.st, en: v.en, fl: (v.mpass == v.n + 1)});
  endtask

  task automatic finish_vec(input vec_t v);
    wait_done();
    repeat (2) @(negedge clk);
    chk("pulses_left", exp_p.size(), 0);
    chk("results_left", exp_r.size(), 0);
    chk("chars_seen", chars_seen, v.n);
    chk("done", done, 1);
    chk("err", err, 0);
    chk("s_ready_done", s_ready, 0);
  endtask

  task automatic run_vec(input vec_t v);
    setup_vec(v);
    for (int i = 0; i < v.n; i++) send_byte(v.bytes[8*i +: 8], i == v.n - 1);
    finish_vec(v);
  endtask

  initial begin
    int i;
    vecs[0] = '{n: 2, bytes: 32'h0000_6261, delay: 3, mpass: 0, st: 0, en: 0};
    vecs[1] = '{n: 2, bytes: 32'h0000_6261, delay: 3, mpass: 2, st: 1, en: 2};
    vecs[2] = '{n: 2, bytes: 32'h0000_6261, delay: 3, mpass: 3, st: 0, en: 5};
    vecs[3] = '{n: 1, bytes: 32'h0000_007A, delay: 0, mpass: 0, st: 0, en: 0};
    vecs[4] = '{n: 3, bytes: 32'h0030_2010, delay: 1, mpass: 1, st: 7, en: 9};
    vecs[5] = '{n: 1, bytes: 32'h0000_0041, delay: 1, mpass: 0, st: 0, en: 0};

    #2;
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_reset", m_reset, 0);
    chk("rst_m_char", m_char, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_chars_seen", chars_seen, 0);
    chk("rst_done_err", {done, err}, 0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Flush-pass match held under 10 cycles of backpressure
    setup_vec(vecs[2]);
    r_ready = 1'b0;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b1);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r_valid) break;
    end
    chk("bp_r_valid_rise", r_valid, 1);
    repeat (10) @(negedge clk);
    chk("bp_r_valid_held", r_valid, 1);
    chk("bp_done_before", done, 0);
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_r_valid_drop", r_valid, 0);
    chk("bp_done_next", done, 0);
    @(negedge clk);
    chk("bp_done", done, 1);
    chk("bp_results_left", exp_r.size(), 0);

    // 0x7A with immediate rdy: first m_reset high to done is 8 cycles
    setup_vec(vecs[3]);
    send_byte(8'h7A, 1'b1);
    wait_mreset(1'b1);
    i = 0;
    while (!done && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("immediate_rdy_latency", i, 8);
    chk("immediate_pulses_left", exp_p.size(), 0);

    // Timeout: err exactly 16 cycles after entering WAIT
    do_reset();
    stub_never      = 1'b1;
    stub_match_pass = 0;
    exp_p.push_back('{ch: 8'h33, last: 1'b0, width: 8'd2});
    send_byte(8'h33, 1'b1);
    wait_mreset(1'b1);
    wait_mreset(1'b0);
    i = 0;
    while (!err && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("timeout_cycles", i, 16);
    chk("timeout_done", done, 1);
    s_valid = 1'b1;
    s_data  = 8'h44;
    repeat (5) @(negedge clk);
    chk("timeout_s_ready", s_ready, 0);
    chk("timeout_m_reset", m_reset, 0);
    chk("timeout_chars", chars_seen, 1);
    s_valid = 1'b0;

    // Reset asserted in WAIT with a match pending
    do_reset();
    stub_never      = 1'b0;
    stub_delay      = 5;
    stub_match_pass = 1;
    stub_start      = 32'd3;
    stub_end        = 32'd4;
    exp_p.push_back('{ch: 8'h55, last: 1'b0, width: 8'd2});
    send_byte(8'h55, 1'b1);
    wait_mreset(1'b1);
    wait_mreset(1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_outputs", {s_ready, m_reset, m_last, r_valid, r_flush, done, err}, 0);
    chk("abort_m_char", m_char, 0);
    chk("abort_chars", chars_seen, 0);
    chk("abort_r_pos", {r_start, r_end}, 0);
    chk("abort_pulses_left", exp_p.size(), 0);
    run_vec(vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/regex_char_sequencer.md
Name: regex_char_sequencer

Overview:
- Hardware initiator for the compiled_regex per-character protocol.
- Takes bytes from a valid/ready input stream and feeds them one at a time to compiled_regex. For each byte it pulses the matcher reset, waits for rdy, and forwards any match positions on a valid/ready result port.
- After the stream's last byte it runs one extra flush pass with m_last=1.
- Sits between the text buffer and the compiled regex core on the synthesized match path.

Parameters:
- POS_W, 32, width of start/end position buses.
- RESET_CYCLES, 2, number of cycles m_reset is held high per character (minimum 1).
- TIMEOUT, 1024, cycles in WAIT without m_rdy before the error state is entered.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of the stream.
- s_ready  out  1  input byte accepted when s_valid and s_ready are both high.
- m_reset  out  1  active-high reset pulse to the matcher.
- m_char  out  8  character presented to the matcher.
- m_last  out  1  flush-pass indicator to the matcher.
- m_rdy  in  1  matcher finished evaluating.
- m_match  in  1  matcher reports a match.
- m_start  in  POS_W  matcher start position.
- m_end  in  POS_W  matcher end position.
- r_valid  out  1  result valid.
- r_ready  in  1  result consumed.
- r_start  out  POS_W  captured start position.
- r_end  out  POS_W  captured end position.
- r_flush  out  1  result came from the flush pass.
- chars_seen  out  32  count of bytes accepted since reset.
- done  out  1  sticky; stream plus flush pass complete.
- err  out  1  sticky; m_rdy timeout occurred.

Behaviour:
- Reset values (reset low):
  - State is IDLE.
  - All outputs are 0, including m_reset, r_valid, done, err and chars_seen.
  - m_char is 0.
  - Internal last_pending is 0.
- Reset asserted mid-operation aborts immediately, with no partial result emitted.
- IDLE:
  - s_ready = 1.
  - On handshake: m_char <= s_data, last_pending <= s_last, m_last <= 0, chars_seen increments, go to PULSE.
- PULSE:
  - m_reset = 1 for exactly RESET_CYCLES cycles; s_ready = 0.
  - Then go to WAIT with m_reset = 0.
  - The first handshake-to-m_reset latency is 1 cycle (m_reset is registered).
- WAIT:
  - m_rdy is sampled only here. Matcher outputs are ignored during PULSE and IDLE.
  - On m_rdy with m_match = 1: capture r_start, r_end and r_flush = m_last, then go to REPORT.
  - On m_rdy with m_match = 0: go to NEXT.
  - The timeout counter resets on entry to WAIT.
  - If the counter reaches TIMEOUT with no m_rdy: go to ERR.
- REPORT:
  - r_valid = 1; r_start, r_end and r_flush are held stable until r_ready.
  - On r_valid and r_ready: r_valid <= 0, go to NEXT.
  - Backpressure stalls the whole sequencer; no result is ever dropped.
- NEXT (single cycle):
  - If m_last = 1: go to DONE.
  - Else if last_pending = 1: m_last <= 1, keep m_char unchanged, go to PULSE (flush pass).
  - Else: go to IDLE.
- DONE:
  - done = 1, s_ready = 0; input bytes are not accepted.
  - Held until reset.
- ERR:
  - err = 1, done = 1, s_ready = 0, m_reset = 0.
  - Held until reset.
- Boundaries:
  - A single-byte stream with s_last = 1 gives two matcher passes: the byte pass, then the flush pass.
  - m_rdy already high on the first cycle of WAIT is a valid completion.
  - If m_rdy and the timeout terminal count occur in the same cycle, m_rdy wins.
  - chars_seen wraps modulo 2^32.
  - The flush pass does not increment chars_seen.

Test Plan:
- Stream "ab" (0x61, 0x62 with s_last) against a stub matcher (rdy 3 cycles after reset falls, no match) -> m_reset pulses 3 times, each 2 cycles wide. The third pulse has m_char = 0x62 and m_last = 1. Then done = 1, chars_seen = 2, r_valid never asserted.
- Stub matches on the second byte with start = 1, end = 2 and r_ready held high -> exactly one r_valid beat with r_start = 1, r_end = 2, r_flush = 0.
- Stub matches only in the flush pass (start = 0, end = 5), with r_ready low for 10 cycles -> r_valid stays high for 10 cycles with values stable. After r_ready goes high, r_flush = 1, then done asserts on the next cycle.
- Stub never raises rdy, TIMEOUT = 16 -> err = 1 and done = 1 exactly 16 cycles after entering WAIT; s_ready = 0 thereafter.
- reset driven low during WAIT with a pending match -> all outputs 0 immediately, with no r_valid. After reset is released, a new single-byte stream 0x41 completes normally and chars_seen = 1.
- Single byte 0x7A with s_last and m_rdy high on the first WAIT cycle -> two passes complete, each in RESET_CYCLES + 1 cycles from the start of PULSE to m_rdy sampling.
